// File: rtl/iiitb_psd_pkg.sv
// Shared types, reset defaults and the masked pattern compare for the
// programmable serial sequence detector.
package iiitb_psd_pkg;

    localparam int unsigned PSD_MAX_LEN = 8;
    localparam int unsigned PSD_DEF_LEN = 5;
    localparam logic [PSD_MAX_LEN-1:0] PSD_DEF_PATTERN = 8'b0001_0111;

    // Compare width; MAX_LEN instances up to this width share one function.
    localparam int unsigned CMP_W = 32;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HUNT  = 2'd1,
        MATCH = 2'd2
    } psd_state_t;

    // True when the low len bits of a and b agree; bits above len are ignored.
    function automatic logic masked_eq(input logic [CMP_W-1:0] a,
                                       input logic [CMP_W-1:0] b,
                                       input int unsigned      len);
        logic [CMP_W-1:0] mask;
        mask = (len >= CMP_W) ? '1 : ((CMP_W'(1) << len) - CMP_W'(1));
        return ((a ^ b) & mask) == '0;
    endfunction

endpackage

// File: rtl/iiitb_psd_hist.sv
// Sample history and fill tracking; flags a pattern match on the bit
// being sampled this cycle.
module iiitb_psd_hist
    import iiitb_psd_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_sample,
    input  logic               i_bit,
    input  logic [MAX_LEN-1:0] i_pattern,
    input  logic [LEN_W-1:0]   i_len,
    input  logic               i_overlap,
    output logic               o_match_c,
    output logic               o_ready_c
);

    localparam int unsigned FW = LEN_W + 1;

    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] w_cand;
    logic [MAX_LEN-1:0] w_hist_nxt;
    logic [LEN_W-1:0]   w_fill_inc;
    logic [LEN_W-1:0]   w_fill_nxt;
    logic               w_gate;

    assign w_cand     = {r_hist[MAX_LEN-2:0], i_bit};
    assign w_fill_inc = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
    // Gate stops matches against the zeros left in hist by reset or clear.
    assign w_gate     = (FW'(r_fill) + FW'(1)) >= FW'(i_len);
    assign o_match_c  = i_sample && w_gate &&
                        masked_eq(CMP_W'(w_cand), CMP_W'(i_pattern), 32'(i_len));
    assign o_ready_c  = w_fill_nxt >= i_len;

    always_comb begin
        w_hist_nxt = r_hist;
        w_fill_nxt = r_fill;
        if (i_clear) begin
            w_hist_nxt = '0;
            w_fill_nxt = '0;
        end else if (i_sample) begin
            w_hist_nxt = w_cand;
            w_fill_nxt = (o_match_c && !i_overlap) ? '0 : w_fill_inc;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_hist <= '0;
            r_fill <= '0;
        end else begin
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
        end
    end

endmodule

// File: rtl/iiitb_psd_fsm.sv
// Runtime-programmable serial sequence detector: config registers, Moore
// match FSM, saturating match counter and config-error pulse.
module iiitb_psd_fsm
    import iiitb_psd_pkg::*;
#(
    parameter int unsigned             MAX_LEN     = PSD_MAX_LEN,
    parameter int unsigned             CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]      DEF_PATTERN = MAX_LEN'(PSD_DEF_PATTERN),
    parameter int unsigned             DEF_LEN     = PSD_DEF_LEN,
    localparam int unsigned            LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sequence_in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    psd_state_t         r_state;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_count;
    logic               r_cfg_err;
    logic               w_sample;
    logic               w_match_c;
    logic               w_ready_c;
    logic               w_len_ok;

    assign w_sample = in_valid && !cfg_load;
    assign w_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

    iiitb_psd_hist #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_hist (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (cfg_load),
        .i_sample  (w_sample),
        .i_bit     (sequence_in),
        .i_pattern (r_pattern),
        .i_len     (r_len),
        .i_overlap (r_overlap),
        .o_match_c (w_match_c),
        .o_ready_c (w_ready_c)
    );

    // Config load outranks count clear, which outranks the counting sample.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= FILL;
            r_pattern <= DEF_PATTERN;
            r_len     <= LEN_W'(DEF_LEN);
            r_overlap <= 1'b1;
            r_count   <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            if (cfg_load) begin
                r_state <= FILL;
                if (w_len_ok) begin
                    r_pattern <= cfg_pattern;
                    r_len     <= cfg_len;
                    r_overlap <= cfg_overlap;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end else begin
                if (w_match_c)      r_state <= MATCH;
                else if (w_ready_c) r_state <= HUNT;
                else                r_state <= FILL;

                if (count_clr)
                    r_count <= '0;
                else if (w_match_c && (r_count != CNT_MAX))
                    r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign detector_out = (r_state == MATCH);
    assign match_count  = r_count;
    assign cfg_err      = r_cfg_err;

endmodule
